// File: rtl/exe_pkg.sv
// Shared field positions, ALU operation codes, exception tag bits and the
// execute-stage state encoding.
package exe_pkg;

  localparam int EXE_CTRL_W = 13;
  localparam int MEM_CTRL_W = 19;
  localparam int WB_CTRL_W  = 10;

  localparam int EXE_SRCB_LO  = 0;
  localparam int EXE_SRCB_HI  = 1;
  localparam int EXE_SRCA     = 2;
  localparam int EXE_ALUOP_LO = 3;
  localparam int EXE_ALUOP_HI = 8;
  localparam int EXE_MUL_LO   = 9;
  localparam int EXE_DIV_HI   = 12;

  localparam int MEM_LW      = 18;
  localparam int MEM_LH      = 17;
  localparam int MEM_SW      = 16;
  localparam int MEM_SH      = 15;
  localparam int MEM_PASS_HI = 14;

  localparam int WB_DEST_LO = 2;
  localparam int WB_DEST_HI = 3;

  localparam int TAG_ADES    = 0;
  localparam int TAG_ADEL    = 1;
  localparam int TAG_OV      = 2;
  localparam int TAG_TRAP_EN = 3;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,
    ALU_ADDU = 6'd1,
    ALU_SUB  = 6'd2,
    ALU_SUBU = 6'd3,
    ALU_AND  = 6'd4,
    ALU_OR   = 6'd5,
    ALU_XOR  = 6'd6,
    ALU_NOR  = 6'd7,
    ALU_SLT  = 6'd8,
    ALU_SLTU = 6'd9,
    ALU_SLL  = 6'd10,
    ALU_SRL  = 6'd11,
    ALU_SRA  = 6'd12,
    ALU_LUI  = 6'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FULL    = 2'd1,
    MD_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Integer ALU: add/sub with signed-overflow flag, logic, compares, shifts
// by the instruction shamt field, and load-upper.
module alu
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [4:0]      i_shamt,
  input  logic [5:0]      i_op,
  output logic [XLEN-1:0] o_result,
  output logic            o_ov
);

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    o_result = '0;
    o_ov     = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_result = w_sum;
        o_ov     = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
      end
      ALU_ADDU: o_result = w_sum;
      ALU_SUB: begin
        o_result = w_diff;
        o_ov     = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_diff[XLEN-1] != i_a[XLEN-1]);
      end
      ALU_SUBU: o_result = w_diff;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_SLL:  o_result = i_b << i_shamt;
      ALU_SRL:  o_result = i_b >> i_shamt;
      ALU_SRA:  o_result = $signed(i_b) >>> i_shamt;
      ALU_LUI:  o_result = i_b << 16;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/exe_fwd_mux.sv
// Priority forwarding select for one source register: the lowest-index
// producer writing that register wins; register 0 is never forwarded.
module exe_fwd_mux #(
  parameter int XLEN = 32,
  parameter int NFWD = 2
) (
  input  logic [4:0]           i_reg,
  input  logic [XLEN-1:0]      i_reg_val,
  input  logic [5*NFWD-1:0]    i_fwd_dest,
  input  logic [XLEN*NFWD-1:0] i_fwd_data,
  output logic [XLEN-1:0]      o_val,
  output logic                 o_hit
);

  always_comb begin
    o_val = i_reg_val;
    o_hit = 1'b0;
    // Walk oldest to youngest so the youngest hit is the last assignment.
    for (int i = NFWD - 1; i >= 0; i--) begin
      if ((i_fwd_dest[i*5 +: 5] == i_reg) && (i_fwd_dest[i*5 +: 5] != 5'd0)) begin
        o_val = i_fwd_data[i*XLEN +: XLEN];
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux2.sv
// Two-input multiplexer.
module mux2 #(
  parameter int W = 32
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mux4.sv
// Four-input multiplexer.
module mux4 #(
  parameter int W = 32
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic [W-1:0] i_d3,
  output logic [W-1:0] o_y
);

  always_comb begin
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/exe_stage_hs.sv
// Execute stage: ID/EXE register with valid/ready handshake, flush, operand
// forwarding, ALU, exception tagging and a fixed-latency mul/div hold.
module exe_stage_hs
  import exe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NFWD   = 2,
  parameter int MD_LAT = 4,
  parameter int TAG_W  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_inst,
  input  logic [XLEN-1:0]       in_rd1,
  input  logic [XLEN-1:0]       in_rd2,
  input  logic [XLEN-1:0]       in_ext,
  input  logic [EXE_CTRL_W-1:0] in_exe_ctrl,
  input  logic [MEM_CTRL_W-1:0] in_mem_ctrl,
  input  logic [WB_CTRL_W-1:0]  in_wb_ctrl,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [5*NFWD-1:0]     fwd_dest,
  input  logic [XLEN*NFWD-1:0]  fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_inst,
  output logic [XLEN-1:0]       out_alu,
  output logic [XLEN-1:0]       out_rs,
  output logic [XLEN-1:0]       out_rt,
  output logic [4:0]            out_dest,
  output logic [MEM_CTRL_W-1:0] out_mem_ctrl,
  output logic [WB_CTRL_W-1:0]  out_wb_ctrl,
  output logic [TAG_W-1:0]      out_tag,
  output logic [XLEN-1:0]       out_badvaddr,
  output logic                  md_start,
  output logic [3:0]            md_op,
  output logic [XLEN-1:0]       md_a,
  output logic [XLEN-1:0]       md_b
);

  localparam int                CNT_W    = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MD_LAT - 1);
  // Trap-enable rides in the tag but is a control bit, not an exception.
  localparam logic [TAG_W-1:0]  TAG_EXC_MASK = ~(TAG_W'(1) << TAG_TRAP_EN);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_md_pend;

  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_inst;
  logic [XLEN-1:0]       r_rd1;
  logic [XLEN-1:0]       r_rd2;
  logic [XLEN-1:0]       r_ext;
  logic [EXE_CTRL_W-1:0] r_exe_ctrl;
  logic [MEM_CTRL_W-1:0] r_mem_ctrl;
  logic [WB_CTRL_W-1:0]  r_wb_ctrl;
  logic [TAG_W-1:0]      r_tag;

  logic                  w_holding;
  logic                  w_fire;
  logic                  w_accept;
  logic                  w_in_md;
  logic [XLEN-1:0]       w_rs_val;
  logic [XLEN-1:0]       w_rt_val;
  logic                  w_rs_hit;
  logic                  w_rt_hit;
  logic [XLEN-1:0]       w_alu_a;
  logic [XLEN-1:0]       w_alu_b;
  logic [XLEN-1:0]       w_alu;
  logic                  w_alu_ov;
  logic                  w_ov;
  logic                  w_adel;
  logic                  w_ades;
  logic                  w_exc;
  logic [TAG_W-1:0]      w_tag;

  // Handshake
  assign w_holding = (r_state != IDLE);
  assign out_valid = (r_state == FULL);
  assign in_ready  = (r_state == IDLE) || ((r_state == FULL) && out_ready);
  assign w_fire    = out_valid && out_ready;
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_in_md   = (|in_exe_ctrl[EXE_DIV_HI:EXE_MUL_LO]) && ((in_tag & TAG_EXC_MASK) == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_in_md ? MD_WAIT : FULL;
          w_cnt_nxt   = w_in_md ? CNT_LOAD : '0;
        end
      end
      FULL: begin
        if (w_fire) begin
          w_state_nxt = w_accept ? (w_in_md ? MD_WAIT : FULL) : IDLE;
          w_cnt_nxt   = (w_accept && w_in_md) ? CNT_LOAD : '0;
        end
      end
      MD_WAIT: begin
        if (r_cnt == '0) w_state_nxt = FULL;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_md_pend <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_md_pend <= w_accept && w_in_md;
    end
  end

  // Payload: captured on accept, otherwise refreshed by forwarding hits while held.
  always_ff @(posedge clk) begin
    // NOTE: payload is cleared on reset so out_* show a known all-zero entry afterwards.
    if (reset) begin
      r_pc       <= '0;
      r_inst     <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_ext      <= '0;
      r_exe_ctrl <= '0;
      r_mem_ctrl <= '0;
      r_wb_ctrl  <= '0;
      r_tag      <= '0;
    end else if (w_accept) begin
      r_pc       <= in_pc;
      r_inst     <= in_inst;
      r_rd1      <= in_rd1;
      r_rd2      <= in_rd2;
      r_ext      <= in_ext;
      r_exe_ctrl <= in_exe_ctrl;
      r_mem_ctrl <= in_mem_ctrl;
      r_wb_ctrl  <= in_wb_ctrl;
      r_tag      <= in_tag;
    end else if (w_holding) begin
      if (w_rs_hit) r_rd1 <= w_rs_val;
      if (w_rt_hit) r_rd2 <= w_rt_val;
    end
  end

  exe_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs (
    .i_reg      (r_inst[25:21]),
    .i_reg_val  (r_rd1),
    .i_fwd_dest (fwd_dest),
    .i_fwd_data (fwd_data),
    .o_val      (w_rs_val),
    .o_hit      (w_rs_hit)
  );

  exe_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rt (
    .i_reg      (r_inst[20:16]),
    .i_reg_val  (r_rd2),
    .i_fwd_dest (fwd_dest),
    .i_fwd_data (fwd_data),
    .o_val      (w_rt_val),
    .o_hit      (w_rt_hit)
  );

  mux2 #(.W(XLEN)) u_mux_a (
    .i_sel (r_exe_ctrl[EXE_SRCA]),
    .i_d0  (w_rs_val),
    .i_d1  (r_pc),
    .o_y   (w_alu_a)
  );

  mux4 #(.W(XLEN)) u_mux_b (
    .i_sel (r_exe_ctrl[EXE_SRCB_HI:EXE_SRCB_LO]),
    .i_d0  (w_rt_val),
    .i_d1  (r_ext),
    .i_d2  (XLEN'(8)),
    .i_d3  ('0),
    .o_y   (w_alu_b)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_shamt  (r_inst[10:6]),
    .i_op     (r_exe_ctrl[EXE_ALUOP_HI:EXE_ALUOP_LO]),
    .o_result (w_alu),
    .o_ov     (w_alu_ov)
  );

  mux4 #(.W(5)) u_mux_dest (
    .i_sel (r_wb_ctrl[WB_DEST_HI:WB_DEST_LO]),
    .i_d0  (r_inst[20:16]),
    .i_d1  (r_inst[15:11]),
    .i_d2  (5'd31),
    .i_d3  (5'd0),
    .o_y   (out_dest)
  );

  // Exceptions
  assign w_ov   = w_alu_ov && r_tag[TAG_TRAP_EN];
  assign w_adel = (r_mem_ctrl[MEM_LW] && (w_alu[1:0] != 2'b00)) || (r_mem_ctrl[MEM_LH] && w_alu[0]);
  assign w_ades = (r_mem_ctrl[MEM_SW] && (w_alu[1:0] != 2'b00)) || (r_mem_ctrl[MEM_SH] && w_alu[0]);

  always_comb begin
    w_tag           = r_tag;
    w_tag[TAG_ADES] = r_tag[TAG_ADES] | w_ades;
    w_tag[TAG_ADEL] = r_tag[TAG_ADEL] | w_adel;
    w_tag[TAG_OV]   = r_tag[TAG_OV]   | w_ov;
  end

  assign w_exc = |(w_tag & TAG_EXC_MASK);

  assign out_pc       = r_pc;
  assign out_inst     = r_inst;
  assign out_alu      = w_alu;
  assign out_rs       = w_rs_val;
  assign out_rt       = w_rt_val;
  assign out_wb_ctrl  = r_wb_ctrl;
  assign out_tag      = w_tag;
  assign out_badvaddr = (w_adel || w_ades) ? w_alu : '0;
  // A faulting store must not reach memory.
  assign out_mem_ctrl = {w_alu[1:0],
                         r_mem_ctrl[MEM_SW] && !w_exc,
                         r_mem_ctrl[MEM_SH] && !w_exc,
                         r_mem_ctrl[MEM_PASS_HI:0]};

  assign md_start = r_md_pend && !w_exc;
  assign md_op    = r_exe_ctrl[EXE_DIV_HI:EXE_MUL_LO];
  assign md_a     = w_rs_val;
  assign md_b     = w_rt_val;

endmodule

// File: tb/tb_exe_stage_hs.sv
// Directed bench for exe_stage_hs: a vector table for single-entry results
// plus hand-written sequences for hold, mul/div wait, flush and reset.
module tb_exe_stage_hs;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_inst, in_rd1, in_rd2, in_ext;
  logic [12:0] in_exe_ctrl;
  logic [18:0] in_mem_ctrl;
  logic [9:0]  in_wb_ctrl;
  logic [6:0]  in_tag;
  logic [9:0]  fwd_dest;
  logic [63:0] fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst, out_alu, out_rs, out_rt, out_badvaddr, md_a, md_b;
  logic [4:0]  out_dest;
  logic [18:0] out_mem_ctrl;
  logic [9:0]  out_wb_ctrl;
  logic [6:0]  out_tag;
  logic        md_start;
  logic [3:0]  md_op;

  int n_checks = 0;
  int n_fail   = 0;

  exe_stage_hs dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_ext(in_ext),
    .in_exe_ctrl(in_exe_ctrl), .in_mem_ctrl(in_mem_ctrl), .in_wb_ctrl(in_wb_ctrl), .in_tag(in_tag),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_alu(out_alu), .out_rs(out_rs), .out_rt(out_rt),
    .out_dest(out_dest), .out_mem_ctrl(out_mem_ctrl), .out_wb_ctrl(out_wb_ctrl), .out_tag(out_tag),
    .out_badvaddr(out_badvaddr), .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, inst, rd1, rd2, ext;
    logic [12:0] exe;
    logic [18:0] mem;
    logic [9:0]  wb;
    logic [6:0]  tag;
    logic [9:0]  fdest;
    logic [63:0] fdata;
    logic [31:0] e_alu;
    logic [4:0]  e_dest;
    logic [6:0]  e_tag;
    logic [31:0] e_bad;
    logic [18:0] e_mem;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, 6'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {6'd8, rs, rt, imm};
  endfunction

  function automatic logic [12:0] ec(input logic [1:0] srcb, input logic srca, input logic [5:0] op,
                                     input logic [1:0] mul, input logic [1:0] dv);
    return {dv, mul, op, srca, srcb};
  endfunction

  function automatic logic [9:0] wbc(input logic [1:0] sel);
    return {6'd0, sel, 2'd0};
  endfunction

  function automatic vec_t mk(
      input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] rd1,
      input logic [31:0] rd2, input logic [31:0] ext, input logic [12:0] exe,
      input logic [18:0] mem, input logic [9:0] wb, input logic [6:0] tag,
      input logic [9:0] fdest, input logic [63:0] fdata, input logic [31:0] e_alu,
      input logic [4:0] e_dest, input logic [6:0] e_tag, input logic [31:0] e_bad,
      input logic [18:0] e_mem);
    vec_t v;
    v.pc = pc; v.inst = inst; v.rd1 = rd1; v.rd2 = rd2; v.ext = ext; v.exe = exe;
    v.mem = mem; v.wb = wb; v.tag = tag; v.fdest = fdest; v.fdata = fdata;
    v.e_alu = e_alu; v.e_dest = e_dest; v.e_tag = e_tag; v.e_bad = e_bad; v.e_mem = e_mem;
    return v;
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [12:0] exe, input logic [6:0] tag);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_inst     = inst;
    in_rd1      = rd1;
    in_rd2      = rd2;
    in_ext      = 32'd0;
    in_exe_ctrl = exe;
    in_mem_ctrl = 19'd0;
    in_wb_ctrl  = wbc(2'd1);
    in_tag      = tag;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0; in_rd1 = '0; in_rd2 = '0; in_ext = '0;
    in_exe_ctrl = '0; in_mem_ctrl = '0; in_wb_ctrl = '0; in_tag = '0;
    fwd_dest = '0; fwd_data = '0;

    // Vector table: pc, inst, rd1, rd2, ext, exe, mem, wb, tag, fdest, fdata | alu, dest, tag, bad, mem
    vq.push_back(mk(32'h0, rtype(1, 2, 3, 0), 32'd100, 32'd7, 0, ec(0, 0, ALU_ADD, 0, 0), 0, wbc(1), 0,
                    {5'd1, 5'd1}, {32'd9, 32'd5}, 32'd12, 5'd3, 7'h00, 0, 19'h00000));
    vq.push_back(mk(32'h4, itype(4, 5, 2), 32'h1000, 0, 32'd2, ec(1, 0, ALU_ADD, 0, 0), 19'h40000, wbc(0), 0,
                    0, 0, 32'h1002, 5'd5, 7'h02, 32'h1002, 19'h40000));
    vq.push_back(mk(32'h8, itype(4, 6, 1), 32'h1000, 0, 32'd1, ec(1, 0, ALU_ADD, 0, 0), 19'h08005, wbc(3), 0,
                    0, 0, 32'h1001, 5'd0, 7'h01, 32'h1001, 19'h20005));
    vq.push_back(mk(32'hC, rtype(1, 2, 7, 0), 32'h7FFFFFFF, 32'd1, 0, ec(0, 0, ALU_ADD, 0, 0), 0, wbc(1), 7'h08,
                    0, 0, 32'h80000000, 5'd7, 7'h0C, 0, 19'h00000));
    vq.push_back(mk(32'h10, rtype(1, 2, 7, 0), 32'h7FFFFFFF, 32'd1, 0, ec(0, 0, ALU_ADD, 0, 0), 0, wbc(1), 7'h00,
                    0, 0, 32'h80000000, 5'd7, 7'h00, 0, 19'h00000));
    vq.push_back(mk(32'h14, rtype(1, 2, 7, 0), 32'h7FFFFFFF, 32'd1, 0, ec(0, 0, ALU_ADDU, 0, 0), 0, wbc(1), 7'h08,
                    0, 0, 32'h80000000, 5'd7, 7'h08, 0, 19'h00000));
    vq.push_back(mk(32'h18, itype(4, 9, 0), 32'h2000, 0, 32'd0, ec(1, 0, ALU_ADD, 0, 0), 19'h10000, wbc(3), 0,
                    0, 0, 32'h2000, 5'd0, 7'h00, 0, 19'h10000));
    vq.push_back(mk(32'h400, 32'h0C000000, 0, 0, 0, ec(2, 1, ALU_ADDU, 0, 0), 0, wbc(2), 0,
                    0, 0, 32'h408, 5'd31, 7'h00, 0, 19'h00000));
    vq.push_back(mk(32'h1C, rtype(0, 2, 4, 5), 0, 32'd3, 0, ec(0, 0, ALU_SLL, 0, 0), 0, wbc(1), 0,
                    0, 0, 32'h60, 5'd4, 7'h00, 0, 19'h00000));
    vq.push_back(mk(32'h20, rtype(1, 2, 6, 0), 32'd50, 32'd10, 0, ec(0, 0, ALU_SUB, 0, 0), 0, wbc(3), 0,
                    {5'd2, 5'd0}, {32'd20, 32'd99}, 32'd30, 5'd0, 7'h00, 0, 19'h40000));
    vq.push_back(mk(32'h24, itype(4, 8, 2), 32'h1000, 0, 32'd2, ec(1, 0, ALU_ADD, 0, 0), 19'h20000, wbc(0), 0,
                    0, 0, 32'h1002, 5'd8, 7'h00, 0, 19'h40000));

    // Reset state
    step();
    step();
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst md_start", md_start, 0);
    check("rst out_tag", out_tag, 0);
    check("rst out_pc", out_pc, 0);
    reset = 1'b0;

    foreach (vq[i]) begin
      in_valid = 1'b1; in_pc = vq[i].pc; in_inst = vq[i].inst; in_rd1 = vq[i].rd1;
      in_rd2 = vq[i].rd2; in_ext = vq[i].ext; in_exe_ctrl = vq[i].exe; in_mem_ctrl = vq[i].mem;
      in_wb_ctrl = vq[i].wb; in_tag = vq[i].tag; fwd_dest = vq[i].fdest; fwd_data = vq[i].fdata;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      #1;
      check($sformatf("v%0d out_valid", i), out_valid, 1);
      check($sformatf("v%0d alu", i), out_alu, vq[i].e_alu);
      check($sformatf("v%0d dest", i), out_dest, vq[i].e_dest);
      check($sformatf("v%0d tag", i), out_tag, vq[i].e_tag);
      check($sformatf("v%0d badvaddr", i), out_badvaddr, vq[i].e_bad);
      check($sformatf("v%0d mem_ctrl", i), out_mem_ctrl, vq[i].e_mem);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      fwd_dest = '0;
      fwd_data = '0;
    end

    // Hold with one-cycle forward hit on rt
    drive(32'h100, rtype(1, 2, 3, 0), 32'd1, 32'd2, ec(0, 0, ALU_ADD, 0, 0), 0);
    step();
    in_valid = 1'b0;
    fwd_dest = {5'd0, 5'd2};
    fwd_data = {32'd0, 32'hA5};
    #1;
    check("hold c1 out_rt", out_rt, 32'hA5);
    check("hold c1 alu", out_alu, 32'hA6);
    step();
    fwd_dest = '0;
    fwd_data = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("hold c%0d out_rt", k + 2), out_rt, 32'hA5);
      check($sformatf("hold c%0d out_pc", k + 2), out_pc, 32'h100);
      check($sformatf("hold c%0d out_valid", k + 2), out_valid, 1);
      check($sformatf("hold c%0d in_ready", k + 2), in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold drained", out_valid, 0);

    // Mul with MD_LAT=4
    drive(32'h200, rtype(1, 2, 0, 0), 32'd6, 32'd7, ec(0, 0, ALU_ADDU, 2'b01, 2'b00), 0);
    step();
    in_valid = 1'b0;
    #1;
    check("mul md_start", md_start, 1);
    check("mul md_a", md_a, 32'd6);
    check("mul md_b", md_b, 32'd7);
    check("mul md_op", md_op, 4'b0001);
    check("mul in_ready", in_ready, 0);
    check("mul out_valid", out_valid, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) begin
        check($sformatf("mul w%0d md_start", k), md_start, 0);
        check($sformatf("mul w%0d out_valid", k), out_valid, 0);
        check($sformatf("mul w%0d in_ready", k), in_ready, 0);
      end else begin
        check("mul done out_valid", out_valid, 1);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Mul carrying an upstream exception: no mul/div launch, straight to FULL
    drive(32'h240, rtype(1, 2, 0, 0), 32'd6, 32'd7, ec(0, 0, ALU_ADDU, 2'b01, 2'b00), 7'h10);
    step();
    in_valid = 1'b0;
    #1;
    check("xmul md_start", md_start, 0);
    check("xmul out_valid", out_valid, 1);
    check("xmul out_tag", out_tag, 7'h10);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Flush during MD_WAIT with a new instruction offered
    drive(32'h280, rtype(1, 2, 0, 0), 32'd3, 32'd4, ec(0, 0, ALU_ADDU, 2'b00, 2'b01), 0);
    step();
    drive(32'h300, rtype(1, 2, 3, 0), 32'd1, 32'd1, ec(0, 0, ALU_ADD, 0, 0), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flushmd out_valid", out_valid, 0);
    check("flushmd in_ready", in_ready, 1);
    check("flushmd md_start", md_start, 0);
    repeat (5) step();
    check("flushmd later out_valid", out_valid, 0);

    // Flush while idle drops the offered instruction
    drive(32'h320, rtype(1, 2, 3, 0), 32'd1, 32'd1, ec(0, 0, ALU_ADD, 0, 0), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flushidle out_valid", out_valid, 0);

    // Back-to-back: fire and accept in the same cycle
    drive(32'h500, rtype(1, 2, 3, 0), 32'd1, 32'd1, ec(0, 0, ALU_ADD, 0, 0), 0);
    step();
    drive(32'h504, rtype(1, 2, 3, 0), 32'd2, 32'd2, ec(0, 0, ALU_ADD, 0, 0), 0);
    out_ready = 1'b1;
    #1;
    check("b2b in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("b2b out_valid", out_valid, 1);
    check("b2b out_pc", out_pc, 32'h504);
    check("b2b alu", out_alu, 32'd4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during MD_WAIT clears state and payload
    drive(32'h600, rtype(1, 2, 0, 0), 32'd8, 32'd9, ec(0, 0, ALU_ADDU, 2'b10, 2'b00), 0);
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rstmd out_valid", out_valid, 0);
    check("rstmd in_ready", in_ready, 1);
    check("rstmd out_pc", out_pc, 0);
    check("rstmd md_start", md_start, 0);
    repeat (5) step();
    check("rstmd later out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
